// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the two-port AHB-lite arbiter in front of the APB bridge.
package ahb_arb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic PORT_S0 = 1'b0;
  localparam logic PORT_S1 = 1'b1;
endpackage

// File: rtl/ahb_arb_hold_stage.sv
// Per-port hold stage: parks an address phase that lost arbitration and
// presents either the parked or the live request to the arbiter.
module ahb_arb_hold_stage
  import ahb_arb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          hsel,
  input  logic          hready,
  input  logic          hwrite,
  input  logic [1:0]    htrans,
  input  logic [AW-1:0] haddr,
  input  logic [2:0]    hsize,
  input  logic          grant,
  output logic          req,
  output logic          pend,
  output logic [AW-1:0] addr_v,
  output logic [1:0]    trans_v,
  output logic [2:0]    size_v,
  output logic          write_v
);
  logic          live;
  logic [AW-1:0] paddr;
  logic [2:0]    psize;
  logic          pwrite;

  assign live = hsel & hready & htrans[1];
  assign req  = pend | live;

  // A live request cannot coexist with pend: the port sees HREADYOUT=0 then.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend   <= 1'b0;
      paddr  <= '0;
      psize  <= '0;
      pwrite <= 1'b0;
    end else if (pend) begin
      if (grant) pend <= 1'b0;
    end else if (live && !grant) begin
      pend   <= 1'b1;
      paddr  <= haddr;
      psize  <= hsize;
      pwrite <= hwrite;
    end
  end

  // A replay is always a fresh NONSEQ to the bridge.
  assign addr_v  = pend ? paddr : haddr;
  assign trans_v = pend ? HTRANS_NONSEQ : htrans;
  assign size_v  = pend ? psize : hsize;
  assign write_v = pend ? pwrite : hwrite;
endmodule

// File: rtl/ahb_apb_arb2.sv
// Two-port round-robin AHB-lite arbiter with burst hold, feeding one AHB-to-APB
// bridge; tracks the data-phase owner to steer HWDATA and HREADYOUT.
module ahb_apb_arb2
  import ahb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL_S0,
  input  logic          HREADY_S0,
  input  logic          HWRITE_S0,
  input  logic [AW-1:0] HADDR_S0,
  input  logic [1:0]    HTRANS_S0,
  input  logic [2:0]    HSIZE_S0,
  input  logic [DW-1:0] HWDATA_S0,
  output logic          HREADYOUT_S0,
  output logic [DW-1:0] HRDATA_S0,
  input  logic          HSEL_S1,
  input  logic          HREADY_S1,
  input  logic          HWRITE_S1,
  input  logic [AW-1:0] HADDR_S1,
  input  logic [1:0]    HTRANS_S1,
  input  logic [2:0]    HSIZE_S1,
  input  logic [DW-1:0] HWDATA_S1,
  output logic          HREADYOUT_S1,
  output logic [DW-1:0] HRDATA_S1,
  output logic          HSEL_M,
  output logic          HWRITE_M,
  output logic          HREADY_M,
  output logic [AW-1:0] HADDR_M,
  output logic [1:0]    HTRANS_M,
  output logic [2:0]    HSIZE_M,
  output logic [DW-1:0] HWDATA_M,
  input  logic          HREADYOUT_M,
  input  logic [DW-1:0] HRDATA_M
);
  localparam int NP = 2;

  logic [NP-1:0]         hsel_s, hready_s, hwrite_s, req, pend, write_v, grant, hrdyout_s;
  logic [NP-1:0][1:0]    htrans_s, trans_v;
  logic [NP-1:0][2:0]    hsize_s, size_v;
  logic [NP-1:0][AW-1:0] haddr_s, addr_v;
  logic [NP-1:0][DW-1:0] hwdata_s;

  logic gnt, win, last_grant, dvld, did;

  assign hsel_s   = {HSEL_S1, HSEL_S0};
  assign hready_s = {HREADY_S1, HREADY_S0};
  assign hwrite_s = {HWRITE_S1, HWRITE_S0};
  assign htrans_s = {HTRANS_S1, HTRANS_S0};
  assign hsize_s  = {HSIZE_S1, HSIZE_S0};
  assign haddr_s  = {HADDR_S1, HADDR_S0};
  assign hwdata_s = {HWDATA_S1, HWDATA_S0};

  for (genvar i = 0; i < NP; i++) begin : g_port
    ahb_arb_hold_stage #(.AW(AW)) u_hold (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .hsel    (hsel_s[i]),
      .hready  (hready_s[i]),
      .hwrite  (hwrite_s[i]),
      .htrans  (htrans_s[i]),
      .haddr   (haddr_s[i]),
      .hsize   (hsize_s[i]),
      .grant   (grant[i]),
      .req     (req[i]),
      .pend    (pend[i]),
      .addr_v  (addr_v[i]),
      .trans_v (trans_v[i]),
      .size_v  (size_v[i]),
      .write_v (write_v[i])
    );
    assign grant[i]     = gnt & (win == 1'(i));
    assign hrdyout_s[i] = pend[i] ? 1'b0 : (dvld && did == 1'(i)) ? HREADYOUT_M : 1'b1;
  end

  // Grants are suppressed while reset is held so the bridge sees IDLE.
  always_comb begin
    gnt = 1'b0;
    win = last_grant;
    if (HRESETn && HREADYOUT_M) begin
      if (req[last_grant] && htrans_s[last_grant] == HTRANS_SEQ) begin
        gnt = 1'b1;
      end else if (req[0] && req[1]) begin
        gnt = 1'b1;
        win = ~last_grant;
      end else if (req[0]) begin
        gnt = 1'b1;
        win = PORT_S0;
      end else if (req[1]) begin
        gnt = 1'b1;
        win = PORT_S1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      last_grant <= PORT_S1;
      dvld       <= 1'b0;
      did        <= PORT_S0;
    end else begin
      if (gnt) last_grant <= win;
      if (HREADYOUT_M) begin
        dvld <= gnt;
        did  <= win;
      end
    end
  end

  assign HSEL_M   = gnt;
  assign HTRANS_M = gnt ? trans_v[win] : HTRANS_IDLE;
  assign HADDR_M  = gnt ? addr_v[win] : '0;
  assign HSIZE_M  = gnt ? size_v[win] : '0;
  assign HWRITE_M = gnt & write_v[win];
  assign HREADY_M = HREADYOUT_M;
  assign HWDATA_M = dvld ? hwdata_s[did] : '0;

  assign HREADYOUT_S0 = hrdyout_s[0];
  assign HREADYOUT_S1 = hrdyout_s[1];
  assign HRDATA_S0    = HRDATA_M;
  assign HRDATA_S1    = HRDATA_M;
endmodule

// File: tb/tb_ahb_apb_arb2.sv
// Bench for ahb_apb_arb2: scripted masters, a zero-wait bridge model with a
// stall input, and a queue of expected forwarded address phases.
module tb_ahb_apb_arb2;
  import ahb_arb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL_S0 = 0, HWRITE_S0 = 0, HSEL_S1 = 0, HWRITE_S1 = 0;
  logic        HREADY_S0, HREADY_S1;
  logic [31:0] HADDR_S0 = '0, HADDR_S1 = '0, HWDATA_S0 = '0, HWDATA_S1 = '0;
  logic [1:0]  HTRANS_S0 = '0, HTRANS_S1 = '0;
  logic [2:0]  HSIZE_S0 = 3'd2, HSIZE_S1 = 3'd2;
  logic        HREADYOUT_S0, HREADYOUT_S1;
  logic [31:0] HRDATA_S0, HRDATA_S1;
  logic        HSEL_M, HWRITE_M, HREADY_M, HREADYOUT_M;
  logic [31:0] HADDR_M, HWDATA_M, HRDATA_M;
  logic [1:0]  HTRANS_M;
  logic [2:0]  HSIZE_M;

  logic        stall = 1'b0;
  logic        bvld;
  logic [31:0] baddr;
  int          errors = 0;
  int          checks = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
  } fwd_t;
  fwd_t exp_q[$];

  always #5 HCLK = ~HCLK;

  // Masters see the arbiter's HREADYOUT as their bus HREADY.
  assign HREADY_S0 = HREADYOUT_S0;
  assign HREADY_S1 = HREADYOUT_S1;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic fwd_t mk(input logic [31:0] a, input logic [1:0] t, input logic w);
    fwd_t f;
    f.addr = a; f.trans = t; f.write = w;
    return f;
  endfunction

  // Bridge model: accepts every address phase, data phase ready unless stalled.
  assign HREADYOUT_M = ~stall;
  assign HRDATA_M    = bvld ? rdata_of(baddr) : '0;
  always @(posedge HCLK) begin
    if (!HRESETn) bvld <= 1'b0;
    else if (HREADY_M) begin
      bvld  <= HSEL_M & HTRANS_M[1];
      baddr <= HADDR_M;
    end
  end

  ahb_apb_arb2 #(.AW(32), .DW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL_S0(HSEL_S0), .HREADY_S0(HREADY_S0), .HWRITE_S0(HWRITE_S0), .HADDR_S0(HADDR_S0),
    .HTRANS_S0(HTRANS_S0), .HSIZE_S0(HSIZE_S0), .HWDATA_S0(HWDATA_S0),
    .HREADYOUT_S0(HREADYOUT_S0), .HRDATA_S0(HRDATA_S0),
    .HSEL_S1(HSEL_S1), .HREADY_S1(HREADY_S1), .HWRITE_S1(HWRITE_S1), .HADDR_S1(HADDR_S1),
    .HTRANS_S1(HTRANS_S1), .HSIZE_S1(HSIZE_S1), .HWDATA_S1(HWDATA_S1),
    .HREADYOUT_S1(HREADYOUT_S1), .HRDATA_S1(HRDATA_S1),
    .HSEL_M(HSEL_M), .HWRITE_M(HWRITE_M), .HREADY_M(HREADY_M), .HADDR_M(HADDR_M),
    .HTRANS_M(HTRANS_M), .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M),
    .HREADYOUT_M(HREADYOUT_M), .HRDATA_M(HRDATA_M)
  );

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w);
    HSEL_S0 = (t != HTRANS_IDLE); HTRANS_S0 = t; HADDR_S0 = a; HWRITE_S0 = w;
  endtask

  task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w);
    HSEL_S1 = (t != HTRANS_IDLE); HTRANS_S1 = t; HADDR_S1 = a; HWRITE_S1 = w;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0; stall = 1'b0;
    drv0(HTRANS_IDLE, '0, 0); drv1(HTRANS_IDLE, '0, 0);
    exp_q.delete();
    next();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    next();
    @(negedge HCLK);
    checks++; if (HREADYOUT_S0 !== 1'b1) begin errors++; $display("FAIL rst_rdy0: got %b exp 1", HREADYOUT_S0); end
    checks++; if (HREADYOUT_S1 !== 1'b1) begin errors++; $display("FAIL rst_rdy1: got %b exp 1", HREADYOUT_S1); end
    checks++; if (HSEL_M !== 1'b0) begin errors++; $display("FAIL rst_hsel: got %b exp 0", HSEL_M); end
    checks++; if (HTRANS_M !== HTRANS_IDLE) begin errors++; $display("FAIL rst_htrans: got %0d exp 0", HTRANS_M); end
    checks++; if (HWDATA_M !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h exp 0", HWDATA_M); end
    HRESETn = 1'b1;
    next();
  endtask

  task automatic test_solo_write();
    fwd_t e;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      case (c)
        1: begin drv0(HTRANS_NONSEQ, 32'h4000_0010, 1); exp_q.push_back(mk(32'h4000_0010, HTRANS_NONSEQ, 1)); end
        2: begin drv0(HTRANS_IDLE, '0, 0); HWDATA_S0 = 32'hDEAD_BEEF; stall = 1'b1; end
        3: stall = 1'b0;
        default: ;
      endcase
      @(negedge HCLK);
      if (HSEL_M) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL solo_fwd: unexpected addr %h", HADDR_M); end
        else begin
          e = exp_q.pop_front();
          if ({HADDR_M, HTRANS_M, HWRITE_M} !== {e.addr, e.trans, e.write}) begin
            errors++; $display("FAIL solo_fwd: got %h/%0d/%b exp %h/%0d/%b", HADDR_M, HTRANS_M, HWRITE_M, e.addr, e.trans, e.write);
          end
        end
      end
      checks++; if (HREADYOUT_S1 !== 1'b1) begin errors++; $display("FAIL solo_rdy1 c%0d: got %b exp 1", c, HREADYOUT_S1); end
      if (c == 2 || c == 3) begin
        checks++; if (HWDATA_M !== 32'hDEAD_BEEF) begin errors++; $display("FAIL solo_wdata c%0d: got %h exp deadbeef", c, HWDATA_M); end
        checks++; if (HREADYOUT_S0 !== (c == 3)) begin errors++; $display("FAIL solo_rdy0 c%0d: got %b exp %b", c, HREADYOUT_S0, c == 3); end
      end
      if (c == 4) begin
        checks++; if (HWDATA_M !== 32'h0) begin errors++; $display("FAIL solo_wdata_idle: got %h exp 0", HWDATA_M); end
      end
      next();
    end
    HWDATA_S0 = '0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL solo_drain: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_tie();
    fwd_t e;
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      case (c)
        1: begin
          drv0(HTRANS_NONSEQ, 32'h4000_0000, 0); drv1(HTRANS_NONSEQ, 32'h4000_0100, 0);
          exp_q.push_back(mk(32'h4000_0000, HTRANS_NONSEQ, 0));
          exp_q.push_back(mk(32'h4000_0100, HTRANS_NONSEQ, 0));
        end
        2: begin drv0(HTRANS_IDLE, '0, 0); drv1(HTRANS_IDLE, '0, 0); end
        default: ;
      endcase
      @(negedge HCLK);
      checks++; if (HSEL_M !== (c != 3)) begin errors++; $display("FAIL tie_hsel c%0d: got %b exp %b", c, HSEL_M, c != 3); end
      if (HSEL_M) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL tie_fwd: unexpected addr %h", HADDR_M); end
        else begin
          e = exp_q.pop_front();
          if ({HADDR_M, HTRANS_M, HWRITE_M} !== {e.addr, e.trans, e.write}) begin
            errors++; $display("FAIL tie_fwd c%0d: got %h/%0d/%b exp %h/%0d/%b", c, HADDR_M, HTRANS_M, HWRITE_M, e.addr, e.trans, e.write);
          end
        end
      end
      if (c == 2) begin
        checks++; if (HREADYOUT_S1 !== 1'b0) begin errors++; $display("FAIL tie_s1_wait: got %b exp 0", HREADYOUT_S1); end
        checks++; if (HREADYOUT_S0 !== 1'b1) begin errors++; $display("FAIL tie_s0_rdy: got %b exp 1", HREADYOUT_S0); end
        checks++; if (HRDATA_S0 !== rdata_of(32'h4000_0000)) begin errors++; $display("FAIL tie_rdata0: got %h exp %h", HRDATA_S0, rdata_of(32'h4000_0000)); end
      end
      if (c == 3) begin
        checks++; if (HREADYOUT_S1 !== 1'b1) begin errors++; $display("FAIL tie_s1_rdy: got %b exp 1", HREADYOUT_S1); end
        checks++; if (HRDATA_S1 !== rdata_of(32'h4000_0100)) begin errors++; $display("FAIL tie_rdata1: got %h exp %h", HRDATA_S1, rdata_of(32'h4000_0100)); end
      end
      next();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tie_drain: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [31:0] q0[$], q1[$];
    logic [31:0] ea;
    int n0 = 0, n1 = 0, grants = 0;
    logic exp_p = PORT_S0, stop = 1'b0, acc0, acc1;
    do_reset();
    for (int c = 0; c < 40 && !(stop && q0.size() == 0 && q1.size() == 0); c++) begin
      if (!stop) begin
        drv0(HTRANS_NONSEQ, 32'h4000_1000 + 32'(4 * n0), 0);
        drv1(HTRANS_NONSEQ, 32'h4000_2000 + 32'(4 * n1), 0);
      end else begin
        drv0(HTRANS_IDLE, '0, 0); drv1(HTRANS_IDLE, '0, 0);
      end
      @(negedge HCLK);
      acc0 = HREADY_S0 && HTRANS_S0 == HTRANS_NONSEQ;
      acc1 = HREADY_S1 && HTRANS_S1 == HTRANS_NONSEQ;
      if (acc0) q0.push_back(HADDR_S0);
      if (acc1) q1.push_back(HADDR_S1);
      if (HSEL_M) begin
        checks++;
        if ((exp_p ? q1.size() : q0.size()) == 0) begin
          errors++; $display("FAIL rr_grant%0d: got addr %h exp port %0d with nothing queued", grants, HADDR_M, exp_p);
        end else begin
          ea = exp_p ? q1.pop_front() : q0.pop_front();
          if (HADDR_M !== ea) begin errors++; $display("FAIL rr_grant%0d: got %h exp %h (port %0d)", grants, HADDR_M, ea, exp_p); end
        end
        exp_p = ~exp_p;
        grants++;
        if (grants >= 8) stop = 1'b1;
      end
      next();
      if (acc0) n0++;
      if (acc1) n1++;
    end
    checks++;
    if (grants < 8 || q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL rr_done: got grants=%0d q0=%0d q1=%0d exp >=8/0/0", grants, q0.size(), q1.size());
    end
  endtask

  task automatic test_burst_hold();
    fwd_t e;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      case (c)
        1: begin drv1(HTRANS_NONSEQ, 32'h4000_0200, 0); exp_q.push_back(mk(32'h4000_0200, HTRANS_NONSEQ, 0)); end
        2: begin
          drv1(HTRANS_SEQ, 32'h4000_0204, 0); exp_q.push_back(mk(32'h4000_0204, HTRANS_SEQ, 0));
          drv0(HTRANS_NONSEQ, 32'h4000_0020, 1);
        end
        3: begin drv1(HTRANS_SEQ, 32'h4000_0208, 0); exp_q.push_back(mk(32'h4000_0208, HTRANS_SEQ, 0)); drv0(HTRANS_IDLE, '0, 0); end
        4: begin
          drv1(HTRANS_SEQ, 32'h4000_020C, 0); exp_q.push_back(mk(32'h4000_020C, HTRANS_SEQ, 0));
          exp_q.push_back(mk(32'h4000_0020, HTRANS_NONSEQ, 1));
        end
        5: drv1(HTRANS_IDLE, '0, 0);
        default: ;
      endcase
      @(negedge HCLK);
      checks++; if (HSEL_M !== (c <= 5)) begin errors++; $display("FAIL burst_hsel c%0d: got %b exp %b", c, HSEL_M, c <= 5); end
      if (HSEL_M) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL burst_fwd: unexpected addr %h", HADDR_M); end
        else begin
          e = exp_q.pop_front();
          if ({HADDR_M, HTRANS_M, HWRITE_M} !== {e.addr, e.trans, e.write}) begin
            errors++; $display("FAIL burst_fwd c%0d: got %h/%0d/%b exp %h/%0d/%b", c, HADDR_M, HTRANS_M, HWRITE_M, e.addr, e.trans, e.write);
          end
        end
      end
      checks++;
      if (HREADYOUT_S0 !== !(c >= 3 && c <= 5)) begin
        errors++; $display("FAIL burst_rdy0 c%0d: got %b exp %b", c, HREADYOUT_S0, !(c >= 3 && c <= 5));
      end
      next();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_drain: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_capture_stall();
    fwd_t e;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      case (c)
        1: begin drv0(HTRANS_NONSEQ, 32'h4000_0030, 1); exp_q.push_back(mk(32'h4000_0030, HTRANS_NONSEQ, 1)); end
        2: begin
          drv0(HTRANS_IDLE, '0, 0); HWDATA_S0 = 32'h1111_2222; stall = 1'b1;
          drv1(HTRANS_NONSEQ, 32'h4000_0300, 0); exp_q.push_back(mk(32'h4000_0300, HTRANS_NONSEQ, 0));
        end
        3: drv1(HTRANS_IDLE, '0, 0);
        7: stall = 1'b0;
        default: ;
      endcase
      @(negedge HCLK);
      if (c >= 2) begin
        checks++; if (HSEL_M !== (c == 7)) begin errors++; $display("FAIL stall_hsel c%0d: got %b exp %b", c, HSEL_M, c == 7); end
      end
      if (HSEL_M) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL stall_fwd: unexpected addr %h", HADDR_M); end
        else begin
          e = exp_q.pop_front();
          if ({HADDR_M, HTRANS_M, HWRITE_M} !== {e.addr, e.trans, e.write}) begin
            errors++; $display("FAIL stall_fwd c%0d: got %h/%0d/%b exp %h/%0d/%b", c, HADDR_M, HTRANS_M, HWRITE_M, e.addr, e.trans, e.write);
          end
        end
      end
      if (c >= 2 && c <= 7) begin
        checks++; if (HREADYOUT_S0 !== (c == 7)) begin errors++; $display("FAIL stall_rdy0 c%0d: got %b exp %b", c, HREADYOUT_S0, c == 7); end
        checks++; if (HWDATA_M !== 32'h1111_2222) begin errors++; $display("FAIL stall_wdata c%0d: got %h exp 11112222", c, HWDATA_M); end
      end
      if (c >= 3) begin
        checks++; if (HREADYOUT_S1 !== (c == 8)) begin errors++; $display("FAIL stall_rdy1 c%0d: got %b exp %b", c, HREADYOUT_S1, c == 8); end
      end
      if (c == 8) begin
        checks++; if (HRDATA_S1 !== rdata_of(32'h4000_0300)) begin errors++; $display("FAIL stall_rdata1: got %h exp %h", HRDATA_S1, rdata_of(32'h4000_0300)); end
      end
      next();
    end
    HWDATA_S0 = '0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_mid_reset();
    fwd_t e;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      case (c)
        1: begin
          drv0(HTRANS_NONSEQ, 32'h4000_0040, 0); drv1(HTRANS_NONSEQ, 32'h4000_0400, 0);
          exp_q.push_back(mk(32'h4000_0040, HTRANS_NONSEQ, 0));
        end
        2: begin drv0(HTRANS_IDLE, '0, 0); drv1(HTRANS_IDLE, '0, 0); stall = 1'b1; HRESETn = 1'b0; end
        3: begin HRESETn = 1'b1; stall = 1'b0; end
        4: begin
          drv0(HTRANS_NONSEQ, 32'h4000_0044, 0); drv1(HTRANS_NONSEQ, 32'h4000_0404, 0);
          exp_q.push_back(mk(32'h4000_0044, HTRANS_NONSEQ, 0));
          exp_q.push_back(mk(32'h4000_0404, HTRANS_NONSEQ, 0));
        end
        5: begin drv0(HTRANS_IDLE, '0, 0); drv1(HTRANS_IDLE, '0, 0); end
        default: ;
      endcase
      @(negedge HCLK);
      if (HSEL_M) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL mrst_fwd: unexpected addr %h", HADDR_M); end
        else begin
          e = exp_q.pop_front();
          if ({HADDR_M, HTRANS_M, HWRITE_M} !== {e.addr, e.trans, e.write}) begin
            errors++; $display("FAIL mrst_fwd c%0d: got %h/%0d/%b exp %h/%0d/%b", c, HADDR_M, HTRANS_M, HWRITE_M, e.addr, e.trans, e.write);
          end
        end
      end
      if (c == 2) begin
        checks++; if (HREADYOUT_S1 !== 1'b0) begin errors++; $display("FAIL mrst_pend1: got %b exp 0", HREADYOUT_S1); end
      end
      if (c == 3) begin
        checks++; if (HREADYOUT_S0 !== 1'b1) begin errors++; $display("FAIL mrst_rdy0: got %b exp 1", HREADYOUT_S0); end
        checks++; if (HREADYOUT_S1 !== 1'b1) begin errors++; $display("FAIL mrst_rdy1: got %b exp 1", HREADYOUT_S1); end
        checks++; if (HSEL_M !== 1'b0) begin errors++; $display("FAIL mrst_hsel: got %b exp 0", HSEL_M); end
        checks++; if (HWDATA_M !== 32'h0) begin errors++; $display("FAIL mrst_hwdata: got %h exp 0", HWDATA_M); end
      end
      next();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mrst_drain: got %0d left exp 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_solo_write();
    test_tie();
    test_round_robin();
    test_burst_hold();
    test_capture_stall();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
